// File: rtl/robo_wheel_driver.sv
// -----------------------------------------------------------------------------
// robo_wheel_driver
// Actuator-side responder for the robot controller's wheel command interface.
// Debounces the per-wheel run commands, soft-ramps each wheel's duty cycle and
// produces a registered PWM drive per wheel. The stop/fault indication and the
// key switch bypass the debouncer, so a halt takes effect without delay.
//
// Ports
//   CLK     in   1      single clock, all state on rising edge
//   RST     in   1      synchronous, active-high reset
//   CH      in   1      key switch; 0 = robot off (forces halt)
//   RE      in   1      left-wheel run command
//   RD      in   1      right-wheel run command
//   LedR    in   1      stop/fault indication (forces halt)
//   PWM_E   out  1      left-wheel PWM drive, registered
//   PWM_D   out  1      right-wheel PWM drive, registered
//   DUTY_E  out  PWM_W  current left duty
//   DUTY_D  out  PWM_W  current right duty
//   STATE   out  2      00 IDLE, 01 RUN, 10 HALT
//   MOVING  out  1      STATE==RUN and at least one duty non-zero
// -----------------------------------------------------------------------------
module robo_wheel_driver #(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned DUTY_MAX  = 200,
    parameter int unsigned RAMP_STEP = 20,
    parameter int unsigned RAMP_DIV  = 16,
    parameter int unsigned DEB_CYC   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CH,
    input  logic             RE,
    input  logic             RD,
    input  logic             LedR,
    output logic             PWM_E,
    output logic             PWM_D,
    output logic [PWM_W-1:0] DUTY_E,
    output logic [PWM_W-1:0] DUTY_D,
    output logic [1:0]       STATE,
    output logic             MOVING
);

    // One extra bit so ramp arithmetic can saturate instead of wrapping.
    localparam int unsigned SUM_W = PWM_W + 1;
    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [SUM_W-1:0] STEP_X   = SUM_W'(RAMP_STEP);
    localparam logic [SUM_W-1:0] MAX_X    = SUM_W'(DUTY_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic               r_halt;
    logic [1:0]         r_samp;       // last sampled {RE,RD}
    logic [DEB_W-1:0]   r_deb_cnt;    // edges the current sample has been seen
    logic [1:0]         r_cmd_acc;    // accepted command {left,right}
    logic [PRE_W-1:0]   r_presc;
    logic [PWM_W-1:0]   r_duty_e;
    logic [PWM_W-1:0]   r_duty_d;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               r_pwm_e;
    logic               r_pwm_d;
    logic               r_moving;

    // ---------------------------------------------------------------------
    // Next-state wires
    // ---------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   w_presc_nxt;
    logic [PWM_W-1:0]   w_duty_e_nxt;
    logic [PWM_W-1:0]   w_duty_d_nxt;
    logic               w_moving_nxt;
    logic               w_tick;
    logic [1:0]         w_cmd_in;

    assign w_cmd_in = {RE, RD};
    assign w_tick   = (r_state == ST_RUN) && (r_presc == PRE_LAST);

    // Saturating one-step ramp of a single wheel's duty toward DUTY_MAX or 0.
    function automatic logic [PWM_W-1:0] f_ramp(input logic [PWM_W-1:0] duty,
                                                 input logic             up);
        logic [SUM_W-1:0] v;
        v = {1'b0, duty};
        if (up) begin
            v = v + STEP_X;
            if (v > MAX_X) begin
                v = MAX_X;
            end
        end else begin
            if (v < STEP_X) begin
                v = '0;
            end else begin
                v = v - STEP_X;
            end
        end
        return v[PWM_W-1:0];
    endfunction

    // Halt path: a single register stage, deliberately not debounced.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= LedR | ~CH;
        end
    end

    // Command debounce: a change restarts the count and keeps the old
    // accepted value; the DEB_CYC-th edge seeing the same pair accepts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_samp    <= 2'b00;
            r_deb_cnt <= '0;
            r_cmd_acc <= 2'b00;
        end else begin
            r_samp <= w_cmd_in;
            if (w_cmd_in != r_samp) begin
                r_deb_cnt <= DEB_ONE;
            end else if (r_deb_cnt >= DEB_LAST) begin
                r_cmd_acc <= r_samp;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_ONE;
            end
        end
    end

    // FSM, prescaler and duty state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_duty_e <= '0;
            r_duty_d <= '0;
            r_moving <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_duty_e <= w_duty_e_nxt;
            r_duty_d <= w_duty_d_nxt;
            r_moving <= w_moving_nxt;
        end
    end

    // FSM next state and ramp; halt has priority over every other event.
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = '0;
        w_duty_e_nxt = r_duty_e;
        w_duty_d_nxt = r_duty_d;

        if (r_halt) begin
            w_state_nxt  = ST_HALT;
            w_duty_e_nxt = '0;
            w_duty_d_nxt = '0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    w_state_nxt  = ST_IDLE;
                    w_duty_e_nxt = '0;
                    w_duty_d_nxt = '0;
                end
                ST_IDLE: begin
                    w_duty_e_nxt = '0;
                    w_duty_d_nxt = '0;
                    // Prescaler stays cleared so the first tick lands
                    // RAMP_DIV cycles after entering RUN.
                    if (r_cmd_acc != 2'b00) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_presc_nxt = (r_presc == PRE_LAST) ? '0
                                                        : r_presc + PRE_W'(1);
                    if ((r_cmd_acc == 2'b00) && (r_duty_e == '0) &&
                        (r_duty_d == '0)) begin
                        w_state_nxt = ST_IDLE;
                        w_presc_nxt = '0;
                    end else if (w_tick) begin
                        w_duty_e_nxt = f_ramp(r_duty_e, r_cmd_acc[1]);
                        w_duty_d_nxt = f_ramp(r_duty_d, r_cmd_acc[0]);
                    end
                end
                default: begin
                    // Encoding 11 is unreachable; recover to IDLE.
                    w_state_nxt  = ST_IDLE;
                    w_duty_e_nxt = '0;
                    w_duty_d_nxt = '0;
                end
            endcase
        end
    end

    // MOVING is registered from next-state values so it tracks STATE/duties.
    assign w_moving_nxt = (w_state_nxt == ST_RUN) &&
                          ((w_duty_e_nxt != '0) || (w_duty_d_nxt != '0));

    // Free-running PWM counter and registered comparators.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
            r_pwm_e   <= 1'b0;
            r_pwm_d   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_pwm_e   <= (r_pwm_cnt < r_duty_e);
            r_pwm_d   <= (r_pwm_cnt < r_duty_d);
        end
    end

    assign PWM_E  = r_pwm_e;
    assign PWM_D  = r_pwm_d;
    assign DUTY_E = r_duty_e;
    assign DUTY_D = r_duty_d;
    assign STATE  = r_state;
    assign MOVING = r_moving;

endmodule

// File: tb/tb_robo_wheel_driver.sv
// -----------------------------------------------------------------------------
// tb_robo_wheel_driver
// Directed bench for robo_wheel_driver. Expected outputs are queued when a
// stimulus step is driven and popped/compared once the DUT has clocked it.
// A second instance with DUTY_MAX=RAMP_STEP=64 provides a duty-64 PWM shape.
// -----------------------------------------------------------------------------
module tb_robo_wheel_driver;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;
    localparam int         DIV    = 16;

    logic       CLK = 1'b0;
    logic       RST, CH, RE, RD, LedR;
    logic       pwm_e, pwm_d, moving;
    logic [7:0] duty_e, duty_d;
    logic [1:0] state;
    logic       u2_pwm_e, u2_pwm_d, u2_moving;
    logic [7:0] u2_duty_e, u2_duty_d;
    logic [1:0] u2_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int entry    = 0;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] de;
        logic [7:0] dd;
        logic       mv;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    always #5 CLK = ~CLK;

    robo_wheel_driver dut (
        .CLK(CLK), .RST(RST), .CH(CH), .RE(RE), .RD(RD), .LedR(LedR),
        .PWM_E(pwm_e), .PWM_D(pwm_d), .DUTY_E(duty_e), .DUTY_D(duty_d),
        .STATE(state), .MOVING(moving)
    );

    robo_wheel_driver #(
        .PWM_W(8), .DUTY_MAX(64), .RAMP_STEP(64), .RAMP_DIV(2), .DEB_CYC(4)
    ) u2 (
        .CLK(CLK), .RST(RST), .CH(CH), .RE(RE), .RD(RD), .LedR(LedR),
        .PWM_E(u2_pwm_e), .PWM_D(u2_pwm_d), .DUTY_E(u2_duty_e),
        .DUTY_D(u2_duty_d), .STATE(u2_state), .MOVING(u2_moving)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            cyc++;
        end
        #1;
    endtask

    // Advance to the next ramp tick edge of the main instance.
    task automatic to_next_tick();
        do begin
            step(1);
        end while (((cyc - entry) % DIV) != 0);
    endtask

    task automatic sb_push(input string tag, input logic [1:0] st,
                           input logic [7:0] de, input logic [7:0] dd,
                           input logic mv);
        exp_t e;
        e.st = st;
        e.de = de;
        e.dd = dd;
        e.mv = mv;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow: observed=empty expected=entry");
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".state"},  32'(state),  32'(e.st));
            chk({t, ".duty_e"}, 32'(duty_e), 32'(e.de));
            chk({t, ".duty_d"}, 32'(duty_d), 32'(e.dd));
            chk({t, ".moving"}, 32'(moving), 32'(e.mv));
        end
    endtask

    task automatic pwm_window(output int ce, output int cd,
                              output int ce2, output int cd2);
        ce = 0; cd = 0; ce2 = 0; cd2 = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            ce  += int'(pwm_e);
            cd  += int'(pwm_d);
            ce2 += int'(u2_pwm_e);
            cd2 += int'(u2_pwm_d);
        end
    endtask

    initial begin
        int ce, cd, ce2, cd2;

        // Reset held with commands active.
        RST = 1'b1; CH = 1'b1; RE = 1'b1; RD = 1'b1; LedR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_push("reset", S_IDLE, 8'd0, 8'd0, 1'b0);
            step(1);
            sb_check();
            chk("reset.pwm_e", 32'(pwm_e), 32'd0);
            chk("reset.pwm_d", 32'(pwm_d), 32'd0);
        end
        RST = 1'b0; RE = 1'b0; RD = 1'b0;
        sb_push("idle0", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(2);
        sb_check();

        // Three-cycle pulse must be filtered.
        RE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_push("pulse", S_IDLE, 8'd0, 8'd0, 1'b0);
            step(1);
            sb_check();
        end
        RE = 1'b0;
        sb_push("pulse_after", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(8);
        sb_check();

        // Held command: accepted on 4th edge, RUN on 5th.
        RE = 1'b1; RD = 1'b1;
        sb_push("deb_accept", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(4);
        sb_check();
        sb_push("run_entry", S_RUN, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        entry = cyc;

        // Ramp up 20 per 16 cycles to 200.
        for (int k = 1; k <= 10; k++) begin
            sb_push("ramp_pre", S_RUN, 8'(20 * (k - 1)), 8'(20 * (k - 1)), k > 1);
            step(15);
            sb_check();
            sb_push("ramp_up", S_RUN, 8'(20 * k), 8'(20 * k), 1'b1);
            step(1);
            sb_check();
        end
        sb_push("full_hold", S_RUN, 8'd200, 8'd200, 1'b1);
        step(20);
        sb_check();

        // PWM shape at duty 200 (main) and 64 (second instance).
        pwm_window(ce, cd, ce2, cd2);
        chk("pwm200.e", 32'(ce), 32'd200);
        chk("pwm200.d", 32'(cd), 32'd200);
        chk("pwm64.e", 32'(ce2), 32'd64);
        chk("pwm64.d", 32'(cd2), 32'd64);
        chk("u2.duty_e", 32'(u2_duty_e), 32'd64);
        chk("u2.duty_d", 32'(u2_duty_d), 32'd64);
        chk("u2.state", 32'(u2_state), 32'(S_RUN));
        chk("u2.moving", 32'(u2_moving), 32'd1);

        // Turn: right wheel ramps down, left stays at full speed.
        RD = 1'b0;
        sb_push("turn_accept", S_RUN, 8'd200, 8'd200, 1'b1);
        step(4);
        sb_check();
        for (int k = 1; k <= 10; k++) begin
            sb_push("turn", S_RUN, 8'd200, 8'(200 - 20 * k), 1'b1);
            to_next_tick();
            sb_check();
        end
        sb_push("turn_floor", S_RUN, 8'd200, 8'd0, 1'b1);
        to_next_tick();
        sb_check();

        // Bring left wheel down to 120.
        RE = 1'b0;
        sb_push("down_accept", S_RUN, 8'd200, 8'd0, 1'b1);
        step(4);
        sb_check();
        for (int k = 1; k <= 4; k++) begin
            sb_push("down", S_RUN, 8'(200 - 20 * k), 8'd0, 1'b1);
            to_next_tick();
            sb_check();
        end

        // Emergency halt via LedR at duty 120.
        LedR = 1'b1;
        sb_push("halt_ledr", S_HALT, 8'd0, 8'd0, 1'b0);
        step(2);
        sb_check();
        step(1);
        chk("halt_ledr.pwm_e", 32'(pwm_e), 32'd0);
        chk("halt_ledr.pwm_d", 32'(pwm_d), 32'd0);
        LedR = 1'b0;
        sb_push("release1", S_HALT, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        sb_push("release2", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();

        // Restart ramp from 0, then halt via key switch at 120.
        RE = 1'b1;
        sb_push("restart_acc", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(4);
        sb_check();
        sb_push("restart_run", S_RUN, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        entry = cyc;
        sb_push("restart_pre", S_RUN, 8'd0, 8'd0, 1'b0);
        step(15);
        sb_check();
        for (int k = 1; k <= 6; k++) begin
            sb_push("restart_up", S_RUN, 8'(20 * k), 8'd0, 1'b1);
            to_next_tick();
            sb_check();
        end
        CH = 1'b0;
        step(1);
        sb_push("halt_ch", S_HALT, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        step(1);
        chk("halt_ch.pwm_e", 32'(pwm_e), 32'd0);
        CH = 1'b1;
        sb_push("ch_rel1", S_HALT, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        sb_push("ch_rel2", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        sb_push("ch_rerun", S_RUN, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        entry = cyc;
        sb_push("rerun_pre", S_RUN, 8'd0, 8'd0, 1'b0);
        step(15);
        sb_check();
        sb_push("rerun_tick", S_RUN, 8'd20, 8'd0, 1'b1);
        step(1);
        sb_check();

        // Release: ramp to 0, then back to IDLE.
        RE = 1'b0;
        sb_push("stop_acc", S_RUN, 8'd20, 8'd0, 1'b1);
        step(4);
        sb_check();
        sb_push("stop_zero", S_RUN, 8'd0, 8'd0, 1'b0);
        step(12);
        sb_check();
        sb_push("stop_idle", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();

        // Duty 0: never high.
        pwm_window(ce, cd, ce2, cd2);
        chk("pwm0.e", 32'(ce), 32'd0);
        chk("pwm0.d", 32'(cd), 32'd0);

        // Reset mid-ramp discards duties immediately.
        RE = 1'b1; RD = 1'b1;
        sb_push("mr_run", S_RUN, 8'd0, 8'd0, 1'b0);
        step(5);
        sb_check();
        entry = cyc;
        sb_push("mr_tick", S_RUN, 8'd20, 8'd20, 1'b1);
        step(16);
        sb_check();
        sb_push("mr_mid", S_RUN, 8'd20, 8'd20, 1'b1);
        step(8);
        sb_check();
        RST = 1'b1;
        sb_push("mr_reset", S_IDLE, 8'd0, 8'd0, 1'b0);
        step(1);
        sb_check();
        chk("mr_reset.pwm_e", 32'(pwm_e), 32'd0);
        RST = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/robo_wheel_driver.md
Name: robo_wheel_driver

Overview:
Actuator-side responder for the robot controller's wheel command interface. It consumes the wheel enables RE/RD, the stop indication LedR and the key switch CH. It debounces the wheel commands, soft-ramps each wheel's duty cycle, and produces per-wheel PWM drive. Halt is immediate. The block sits between the combinational controller outputs and the motor power stage.

Parameters:
PWM_W, 8, width of PWM counter and duty registers
DUTY_MAX, 200, full-speed duty; must be < 2^PWM_W
RAMP_STEP, 20, duty increment/decrement per ramp tick
RAMP_DIV, 16, clock cycles per ramp tick (>=2)
DEB_CYC, 4, consecutive stable cycles needed to accept a wheel command (>=1)

Ports:
CLK  in  1  single clock, all state on rising edge
RST  in  1  synchronous, active-high reset
CH  in  1  key switch; 0 = robot off
RE  in  1  left-wheel run command from controller
RD  in  1  right-wheel run command from controller
LedR  in  1  stop/fault indication from controller
PWM_E  out  1  left-wheel PWM drive, registered
PWM_D  out  1  right-wheel PWM drive, registered
DUTY_E  out  PWM_W  current left duty
DUTY_D  out  PWM_W  current right duty
STATE  out  2  FSM state: 00 IDLE, 01 RUN, 10 HALT
MOVING  out  1  STATE==RUN and (DUTY_E!=0 or DUTY_D!=0)

Behaviour:
- Reset (RST=1 at edge): all outputs 0, STATE=IDLE. PWM counter, prescaler, debounce counter, accepted command cmd_acc=00 and halt register all cleared. Reset mid-ramp discards duties immediately.
- Halt path (not debounced): halt_r <= LedR | ~CH each edge. One register stage, so latency is 1 cycle.
- Command debounce:
  - {RE,RD} are sampled each edge.
  - cmd_acc takes the sampled pair on the DEB_CYC-th consecutive edge it is unchanged.
  - Any change restarts the count.
  - Pulses shorter than DEB_CYC cycles never reach cmd_acc.
- FSM, priority halt_r > everything:
  - Any state, halt_r=1 -> HALT. DUTY_E=DUTY_D=0 on the same edge.
  - HALT, halt_r=0 -> IDLE.
  - IDLE, cmd_acc!=00 -> RUN. Prescaler cleared on entry.
  - RUN, cmd_acc==00 and both duties 0 -> IDLE.
  - STATE=11 is unreachable; if ever reached, treated as IDLE next edge.
- Ramp (RUN only):
  - Prescaler counts 0..RAMP_DIV-1 and ticks when it reaches RAMP_DIV-1. First tick is RAMP_DIV cycles after RUN entry.
  - On tick, per wheel: if the cmd_acc bit is 1, duty = min(duty+RAMP_STEP, DUTY_MAX); else duty = max(duty-RAMP_STEP, 0).
  - Arithmetic is done in PWM_W+1 bits, saturating; no wrap.
  - A command change mid-ramp reverses that wheel's direction at the next tick.
  - IDLE holds duties at 0.
- PWM:
  - Free-running PWM_W-bit counter, wraps 2^PWM_W-1 -> 0.
  - PWM_X <= (cnt < DUTY_X), registered.
  - Duty 0 gives constant low. Output is never constant high, since DUTY_MAX < 2^PWM_W.
- Simultaneous events:
  - halt_r rising on a ramp tick: duties go to 0, not ramp.
  - Command change on the same edge as acceptance: the count restarts and the old value is kept.

Test Plan:
- Reset: hold RST 3 cycles with RE=RD=1, CH=1 -> STATE=00, duties 0, PWM low, MOVING=0 throughout.
- Debounce: CH=1, LedR=0, RE pulses high for 3 cycles -> cmd_acc stays 00, STATE=IDLE. RE held high -> STATE=01 after DEB_CYC+1 edges.
- Ramp up/down:
  - RE=RD=1 held: DUTY_E/DUTY_D step 20,40..200 every 16 cycles and reach 200 after 10 ticks (160 cycles after RUN entry), then stay at 200.
  - Release both: duties step down to 0, then STATE=IDLE.
- Turn: at full speed, RD drops to 0 -> DUTY_D decrements 20/tick to 0 while DUTY_E stays 200, MOVING=1.
- Emergency halt:
  - LedR=1 at duty 120 -> next edge halt_r=1, STATE=10, duties 0, PWM low within 2 cycles.
  - CH=0 behaves identically.
  - On release -> IDLE, then ramp restarts from 0.
- PWM shape: force duty 64 (PWM_W=8) -> PWM_E high 64 of every 256 cycles. Duty 0 -> never high.
